cic_cfg_seq: RTL
================

CIC_CFG_SEQ -- requirements
Module: cic_cfg_seq

Interface
REQ-001 Parameter RST_CYC, default 40: number of dclk cycles the filter reset is held after configuration, range 2..255.
REQ-002 dclk  in  1  data/sequencer clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 req  in  1  one-cycle request to (re)configure and restart the CIC filter.
REQ-005 stop  in  1  abort: return to IDLE with filter held in reset.
REQ-006 req_xmt  in  1  requested direction: 1 interpolate (transmit), 0 decimate (receive).
REQ-007 req_gain  in  16  gain word: [15:10] exponent, [9:6] integer gain, [5:0] fractional gain.
REQ-008 req_rate  in  12  rate factor minus 1.
REQ-009 req_nch  in  1  channel-count bit; 1 = two channels.
REQ-010 ovf  in  1  filter overflow flag from the datapath.
REQ-011 cin  out  16  configuration data to filter.
REQ-012 cwr  out  2  configuration register select: 1 gain, 2 rate, 0 none.
REQ-013 cclk  out  1  configuration write strobe; filter captures cin/cwr on its rising edge.
REQ-014 xmt  out  1  direction to filter.
REQ-015 frst  out  1  filter reset, active high.
REQ-016 ce  out  1  channel phase: 0 = channel X, 1 = channel Y.
REQ-017 busy  out  1  configuration/reset sequence in progress.
REQ-018 done  out  1  one-cycle pulse when the filter is released into RUN.
REQ-019 rej  out  1  one-cycle pulse when req is ignored.
REQ-020 ovf_flag  out  1  sticky overflow indicator.

Function
REQ-021 The FSM SHALL have states IDLE, C1L, C1H, C2L, C2H, CLR, HOLD, RUN; all outputs registered.
REQ-022 req SHALL be accepted only in IDLE or RUN; on acceptance req_xmt/req_gain/req_rate/req_nch latch internally and the next state is C1L.
REQ-023 req in any other state SHALL be ignored with rej=1 on the following cycle; latched parameters unchanged.
REQ-024 Sequence: C1L→C1H→C2L→C2H→CLR→HOLD, one cycle each except HOLD.
REQ-025 C1L/C1H: cwr=1, cin=latched gain; C2L/C2H: cwr=2, cin={nch,3'b000,rate}; otherwise cwr=0, cin=0.
REQ-026 cclk SHALL be 1 only in C1H and C2H, giving cin/cwr one full cycle of setup before each rising cclk edge.
REQ-027 xmt SHALL update to the latched direction on entry to C1L and hold until the next accepted req.
REQ-028 frst SHALL be 1 in every state except RUN.
REQ-029 HOLD SHALL last exactly RST_CYC cycles using an 8-bit down-counter loaded on entry, then go to RUN.
REQ-030 done SHALL pulse for exactly the first RUN cycle; busy=1 in C1L through HOLD inclusive.
REQ-031 ce SHALL be 0 outside RUN, 0 in the first RUN cycle, and toggle every cycle thereafter.
REQ-032 ovf_flag SHALL set on any RUN cycle with ovf=1 and clear only on req acceptance or reset.
REQ-033 stop SHALL force IDLE on the next edge from any state (frst=1, ce=0, cwr=0, cclk=0, busy=0); stop takes priority over simultaneous req, and no rej is generated.
REQ-034 req accepted in RUN SHALL restart the sequence immediately (frst reasserts the next cycle).

Reset
REQ-035 On rst: state IDLE, cin=0, cwr=0, cclk=0, xmt=0, frst=1, ce=0, busy=0, done=0, rej=0, ovf_flag=0, latched params 0.
REQ-036 Reset SHALL take effect asynchronously mid-sequence, including during C1H/C2H (cclk drops at once).

Verification
REQ-037 req at edge 0 with xmt=1, gain=16'h7100, rate=12'h00F, nch=1 -> cwr=1/cin=7100 at cycles 1-2, cclk high at 2; cwr=2/cin=800F at 3-4, cclk high at 4; frst falls and done pulses at cycle 46; ce toggles from 47.
REQ-038 Same request with xmt=0 issued while in RUN -> frst=1 at next cycle, xmt=0 from C1L, full sequence repeats, done 46 cycles after accept.
REQ-039 req at cycle 10 of HOLD -> rej pulse, sequence timing and latched values unchanged.
REQ-040 stop and req on the same edge during C2L -> IDLE, no rej, frst=1, cwr=0; later req runs the full sequence.
REQ-041 ovf=1 for one RUN cycle -> ovf_flag=1 and holds; next accepted req clears it.
REQ-042 rst asserted during C1H -> cclk=0, frst=1, all outputs at reset values without a clock edge.

Source files
------------

// File: rtl/cic_cfg_seq.sv
// Configuration and restart sequencer for a CIC filter: writes gain and rate
// registers, holds the filter in reset for RST_CYC cycles, then releases it.
module cic_cfg_seq #(
   parameter int unsigned RST_CYC = 40
) (
   input  logic        dclk,
   input  logic        rst,
   input  logic        req,
   input  logic        stop,
   input  logic        req_xmt,
   input  logic [15:0] req_gain,
   input  logic [11:0] req_rate,
   input  logic        req_nch,
   input  logic        ovf,
   output logic [15:0] cin,
   output logic [1:0]  cwr,
   output logic        cclk,
   output logic        xmt,
   output logic        frst,
   output logic        ce,
   output logic        busy,
   output logic        done,
   output logic        rej,
   output logic        ovf_flag
);

   typedef enum logic [2:0] {IDLE, C1L, C1H, C2L, C2H, CLR, HOLD, RUN} state_t;

   localparam logic [7:0] HOLD_LOAD = 8'(RST_CYC - 1);

   state_t      state;
   state_t      state_nx;
   logic [15:0] gain_l;
   logic [15:0] gain_nx;
   logic [11:0] rate_l;
   logic [11:0] rate_nx;
   logic        nch_l;
   logic        nch_nx;
   logic [7:0]  cnt;
   logic        accept;
   logic        ignore;

   // Next-state decode; stop overrides everything, including a same-cycle req.
   always_comb begin
      accept   = 1'b0;
      ignore   = 1'b0;
      state_nx = state;
      if (req && !stop) begin
         if (state == IDLE || state == RUN) begin
            accept = 1'b1;
         end else begin
            ignore = 1'b1;
         end
      end else begin
         accept = 1'b0;
         ignore = 1'b0;
      end
      if (stop) begin
         state_nx = IDLE;
      end else if (accept) begin
         state_nx = C1L;
      end else begin
         case (state)
            C1L:     state_nx = C1H;
            C1H:     state_nx = C2L;
            C2L:     state_nx = C2H;
            C2H:     state_nx = CLR;
            CLR:     state_nx = HOLD;
            HOLD:    state_nx = (cnt == 8'd0) ? RUN : HOLD;
            RUN:     state_nx = RUN;
            default: state_nx = IDLE;
         endcase
      end
      gain_nx = accept ? req_gain : gain_l;
      rate_nx = accept ? req_rate : rate_l;
      nch_nx  = accept ? req_nch  : nch_l;
   end

   // State, latched request and outputs, all derived from the next state so
   // that every output is a flop aligned with the state it describes.
   always_ff @(posedge dclk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         gain_l   <= 16'h0000;
         rate_l   <= 12'h000;
         nch_l    <= 1'b0;
         cnt      <= 8'd0;
         cin      <= 16'h0000;
         cwr      <= 2'd0;
         cclk     <= 1'b0;
         xmt      <= 1'b0;
         frst     <= 1'b1;
         ce       <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         rej      <= 1'b0;
         ovf_flag <= 1'b0;
      end else begin
         state  <= state_nx;
         gain_l <= gain_nx;
         rate_l <= rate_nx;
         nch_l  <= nch_nx;
         if (accept) begin
            xmt <= req_xmt;
         end else begin
            xmt <= xmt;
         end
         // Load on HOLD entry so HOLD lasts exactly RST_CYC cycles.
         if (state_nx == HOLD && state != HOLD) begin
            cnt <= HOLD_LOAD;
         end else if (state == HOLD) begin
            cnt <= cnt - 8'd1;
         end else begin
            cnt <= cnt;
         end
         case (state_nx)
            C1L, C1H: begin
               cwr <= 2'd1;
               cin <= gain_nx;
            end
            C2L, C2H: begin
               cwr <= 2'd2;
               cin <= {nch_nx, 3'b000, rate_nx};
            end
            default: begin
               cwr <= 2'd0;
               cin <= 16'h0000;
            end
         endcase
         cclk <= (state_nx == C1H) || (state_nx == C2H);
         frst <= (state_nx != RUN);
         busy <= (state_nx != IDLE) && (state_nx != RUN);
         done <= (state == HOLD) && (state_nx == RUN);
         ce   <= (state == RUN && state_nx == RUN) ? ~ce : 1'b0;
         rej  <= ignore;
         if (accept) begin
            ovf_flag <= 1'b0;
         end else if (state == RUN && ovf) begin
            ovf_flag <= 1'b1;
         end else begin
            ovf_flag <= ovf_flag;
         end
      end
   end

endmodule
